// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry packing and count-width helper for the fetch queue
package fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo_mem.sv
// fetch_fifo_mem: DEPTH x W storage with one write port and an async read port
module fetch_fifo_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = ADDR_W_DEF + INSTR_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction-fetch buffer between PC/imem and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         pc,
  output logic                      pc_en,
  input  logic [INSTR_W-1:0]        imem_rdata,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W:0] used;
  logic issue, push, pop;
  // Credit counts the word already requested from imem so a push never finds the queue full.
  always_comb begin
    used = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    pc_en = ~reset & (flush | (used < (CNT_W+1)'(DEPTH)));
    out_valid = (count_q != '0) & ~flush & ~reset;
    issue = pc_en & ~flush;
    push = inflight_q & ~flush;
    pop = out_valid & out_ready;
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
    count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = issue;
    inflight_pc_d = issue ? pc : inflight_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  fetch_fifo_mem #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({inflight_pc_q, imem_rdata}),
    .raddr (rd_ptr_q),
    .rdata ({out_pc, out_instr})
  );
  assign count = count_q;
  assert property (@(posedge clk) disable iff (reset) !(push && count_q == CNT_W'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and a queue-based reference model
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  logic clk, reset, pc_en, flush, out_valid, out_ready;
  logic [7:0] pc, out_pc, br_target;
  logic [31:0] imem_rdata, out_instr;
  logic [2:0] count;
  int checks = 0, failures = 0;
  bit mon_en = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .imem_rdata(imem_rdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Environment: PC counter and a synchronous imem whose word encodes its address
  initial begin pc = 0; imem_rdata = 0; end
  always @(posedge clk) begin
    imem_rdata <= 32'hA000_0000 | {24'd0, pc};
    if (reset) pc <= 0;
    else if (pc_en) pc <= flush ? br_target : pc + 8'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc,instr} plus one outstanding imem request
  fetch_entry_t mq[$];
  int m_inf = 0;
  logic [7:0] m_inf_pc = 0;
  always @(posedge clk) begin : model
    int sz;
    bit en;
    sz = mq.size();
    en = !reset && (flush || sz + m_inf < DEPTH);
    if (reset || flush) begin
      mq.delete();
      m_inf = 0;
    end else begin
      if (sz != 0 && out_ready) void'(mq.pop_front());
      if (m_inf != 0) mq.push_back('{pc: m_inf_pc, instr: imem_rdata});
      m_inf = en ? 1 : 0;
      if (en) m_inf_pc = pc;
    end
  end

  bit e_en, e_v;
  always @(negedge clk) begin
    if (mon_en) begin
      e_en = !reset && (flush || mq.size() + m_inf < DEPTH);
      e_v = !reset && !flush && mq.size() != 0;
      chk("m_pc_en", pc_en, e_en);
      chk("m_valid", out_valid, e_v);
      chk("m_count", count, mq.size());
      if (e_v) begin
        chk("m_out_pc", out_pc, mq[0].pc);
        chk("m_out_instr", out_instr, mq[0].instr);
      end
    end
  end

  typedef struct {
    bit pre_rst;
    bit fl, rdy;
    bit en, vld;
    logic [2:0] cnt;
    logic [7:0] opc;
  } vec_t;
  vec_t tv[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    flush = 0;
    repeat (n) @(posedge clk);
    #1;
    reset = 0;
  endtask

  function automatic vec_t mk(bit p, bit r, bit e, bit v, int c, int o);
    return '{pre_rst: p, fl: 0, rdy: r, en: e, vld: v, cnt: 3'(c), opc: 8'(o)};
  endfunction

  initial begin
    int last, en_hi, en_lo;
    reset = 1; flush = 0; out_ready = 1; br_target = 0;
    tick();
    mon_en = 1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc_en", pc_en, 0);
    // Streaming with out_ready=1, then back-pressure from cycle 0 and release
    tv[0] = mk(1, 1, 1, 0, 0, 0);
    tv[1] = mk(0, 1, 1, 0, 0, 0);
    for (int i = 2; i < 8; i++) tv[i] = mk(0, 1, 1, 1, 1, i - 2);
    tv[8]  = mk(1, 0, 1, 0, 0, 0);
    tv[9]  = mk(0, 0, 1, 0, 0, 0);
    tv[10] = mk(0, 0, 1, 1, 1, 0);
    tv[11] = mk(0, 0, 1, 1, 2, 0);
    tv[12] = mk(0, 0, 0, 1, 3, 0);
    tv[13] = mk(0, 0, 0, 1, 4, 0);
    tv[14] = mk(0, 0, 0, 1, 4, 0);
    tv[15] = mk(0, 1, 0, 1, 4, 0);
    tv[16] = mk(0, 1, 1, 1, 3, 1);
    tv[17] = mk(0, 1, 1, 1, 2, 2);
    tv[18] = mk(0, 1, 1, 1, 2, 3);
    tv[19] = mk(0, 1, 1, 1, 2, 4);
    for (int i = 0; i < 20; i++) begin
      if (tv[i].pre_rst) do_reset(3);
      flush = tv[i].fl;
      out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("tv%0d_pc_en", i), pc_en, tv[i].en);
      chk($sformatf("tv%0d_valid", i), out_valid, tv[i].vld);
      chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
      if (tv[i].vld) chk($sformatf("tv%0d_out_pc", i), out_pc, tv[i].opc);
      tick();
    end
    // Flush with pc 5..7 queued and pc 8 in flight
    do_reset(2);
    out_ready = 1;
    repeat (7) tick();
    out_ready = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t3_full_count", count, 3);
    chk("t3_head_pc", out_pc, 5);
    chk("t3_no_credit", pc_en, 0);
    flush = 1; br_target = 8'h20;
    @(negedge clk);
    chk("t3_flush_valid", out_valid, 0);
    chk("t3_flush_pc_en", pc_en, 1);
    tick();
    flush = 0;
    @(negedge clk);
    chk("t3_post_count", count, 0);
    chk("t3_post_valid", out_valid, 0);
    chk("t3_post_pc_en", pc_en, 1);
    out_ready = 1;
    tick(); tick();
    @(negedge clk);
    chk("t3_first_valid", out_valid, 1);
    chk("t3_first_pc", out_pc, 8'h20);
    tick();
    @(negedge clk);
    chk("t3_second_pc", out_pc, 8'h21);
    // Flush during a live handshake
    do_reset(2);
    out_ready = 1;
    repeat (4) tick();
    flush = 1; br_target = 8'h40;
    @(negedge clk);
    chk("t4_valid_in_flush", out_valid, 0);
    tick();
    flush = 0;
    @(negedge clk);
    chk("t4_count_after", count, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("t4_target_pc", out_pc, 8'h40);
    chk("t4_target_valid", out_valid, 1);
    // Alternating out_ready while full
    do_reset(2);
    out_ready = 0;
    repeat (6) tick();
    last = -1; en_hi = 0; en_lo = 0;
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
      chk("t5_count_range", (count >= 3 && count <= 4), 1);
      if (pc_en) en_hi++; else en_lo++;
      if (out_valid && out_ready) begin
        chk("t5_seq", out_pc, 8'(last + 1));
        last = out_pc;
      end
      tick();
    end
    chk("t5_pc_en_toggles", (en_hi > 0 && en_lo > 0), 1);
    // Reset with three entries queued and one in flight
    do_reset(2);
    out_ready = 0;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_pre_count", count, 3);
    reset = 1;
    @(negedge clk);
    chk("t6_rst_pc_en", pc_en, 0);
    chk("t6_rst_valid", out_valid, 0);
    tick();
    @(negedge clk);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid2", out_valid, 0);
    tick();
    reset = 0;
    out_ready = 1;
    @(negedge clk);
    chk("t6_first_pc_en", pc_en, 1);
    repeat (2) tick();
    @(negedge clk);
    chk("t6_first_valid", out_valid, 1);
    chk("t6_first_pc", out_pc, 0);
    // Random traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom % 64 == 0);
      flush = ($urandom % 8 == 0);
      out_ready = ($urandom % 3 != 0);
      br_target = 8'($urandom);
    end
    tick();
    reset = 0; flush = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
